muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have no parameters; the data width is fixed at 32.
REQ-002 The module SHALL have one clock, `clock`, and an asynchronous active-low reset, `reset_n`.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  EX presents a mul/div operation this cycle.
REQ-006 muldiv_op  input  muldiv_op_t  requested operation: OP_MUL, OP_DIV, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO; any other value means no action.
REQ-007 muldiv_op_u  input  1  1 selects unsigned MUL/DIV; 0 selects signed.
REQ-008 A  input  32  forwarded rs operand (multiplicand or dividend); also the MTHI/MTLO data.
REQ-009 B  input  32  forwarded rt operand (multiplier or divisor).
REQ-010 flush  input  1  cancels any in-flight MUL/DIV.
REQ-011 stall  output  1  EX must hold its current instruction.
REQ-012 busy  output  1  a MUL/DIV is in progress.
REQ-013 hi  output  32  architectural HI register.
REQ-014 lo  output  32  architectural LO register.

Function
REQ-015 The FSM SHALL have three states: IDLE, ITER and FIXUP; busy SHALL be 1 whenever the state is not IDLE.
REQ-016 A request is accepted when req_valid=1 and busy=0; stall SHALL equal req_valid & busy, for every op including MFHI and MFLO.
REQ-017 An accepted MTHI or MTLO SHALL write A into hi or lo at that rising edge, and the FSM SHALL remain in IDLE.
REQ-018 An accepted MUL or DIV SHALL latch the operand magnitudes, the result signs and the op type, load a 5-bit counter with 31, and enter ITER.
- Magnitudes are the two's-complement absolute values when muldiv_op_u=0, and the raw operands when muldiv_op_u=1.
REQ-019 In ITER, the unit SHALL perform one radix-2 step per cycle: shift-add for MUL, restoring subtract for DIV.
- The counter decrements each step.
- At count 0 the FSM goes to FIXUP, for exactly 32 ITER cycles in total.
REQ-020 In FIXUP, the unit SHALL apply the sign correction, write both hi and lo, and return to IDLE.
- Sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
REQ-021 The latency SHALL be as follows: a MUL/DIV accepted at edge N updates hi/lo at edge N+33, and busy is 1 from after edge N until after edge N+33.
REQ-022 A back-to-back request SHALL be accepted at edge N+34 at the earliest, i.e. in the first cycle busy=0.
REQ-023 MUL SHALL write {hi,lo} = the full 64-bit product.
REQ-024 DIV SHALL write lo = the quotient and hi = the remainder.
REQ-025 DIV with B=0 SHALL write lo=32'hFFFFFFFF and hi=A regardless of signedness, with the normal latency.
REQ-026 Signed DIV of 32'h80000000 by 32'hFFFFFFFF SHALL write lo=32'h80000000 and hi=0.
REQ-027 hi and lo SHALL change only at an MTHI/MTLO acceptance or at FIXUP; the outputs are registered, and MFHI/MFLO read them directly.
REQ-028 flush=1 SHALL force the state to IDLE at the next edge with hi/lo unchanged.
REQ-029 A request coinciding with flush SHALL NOT be accepted.

Reset
REQ-030 On reset_n=0, the unit SHALL immediately set state=IDLE, hi=0, lo=0, counter=0, busy=0 and stall=0, including when reset is asserted mid-operation.
REQ-031 No partial result SHALL reach hi/lo after a reset.

Structure
REQ-032 muldiv_op_t SHALL remain in pipTypes; muldiv_state_t {IDLE, ITER, FIXUP} and the constant MULDIV_ITERS=32 SHALL be added to pipTypes.
REQ-033 The design SHALL be a single module with no sub-module, sharing one 33-bit adder/subtractor between the MUL and DIV steps.

Verification
REQ-034 Unsigned MUL 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 at edge N+33; busy high for exactly 33 cycles.
REQ-035 Signed DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; signed DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-036 DIV 5 / 0 -> lo=32'hFFFFFFFF, hi=5 after 33 cycles.
REQ-037 MFLO issued one cycle after MUL 3x4 -> stall=1 for 33 cycles, then lo=12 visible with stall=0.
REQ-038 MTHI 32'h1234 while idle -> hi=32'h1234 next cycle, busy stays 0; MTLO while busy -> stall=1, lo unchanged.
REQ-039 flush at ITER count 10 -> IDLE next cycle, hi/lo hold their previous values; reset_n low mid-DIV -> hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared pipeline types for the multiply/divide unit: operation codes,
// FSM states and the iteration count of the radix-2 datapath.
package pipTypes;

  localparam int MULDIV_ITERS = 32;
  localparam logic [4:0] ITER_LAST = 5'(MULDIV_ITERS - 1);

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_MUL  = 3'd1,
    OP_DIV  = 3'd2,
    OP_MTHI = 3'd3,
    OP_MTLO = 3'd4,
    OP_MFHI = 3'd5,
    OP_MFLO = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } muldiv_state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage <-> multiply/divide unit request bus and HI/LO result view.
interface muldiv_unit_if;
  import pipTypes::*;

  logic        req_valid;
  muldiv_op_t  muldiv_op;
  logic        muldiv_op_u;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output req_valid, muldiv_op, muldiv_op_u, A, B, flush,
    input  stall, busy, hi, lo
  );

  modport slave (
    input  req_valid, muldiv_op, muldiv_op_u, A, B, flush,
    output stall, busy, hi, lo
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MUL/DIV unit with architectural HI/LO registers; one
// shared 33-bit adder performs shift-add multiply and restoring divide.
module muldiv_unit
  import pipTypes::*;
(
  input logic          clock,
  input logic          reset_n,
  muldiv_unit_if.slave bus
);

  muldiv_state_t state, state_nxt;
  logic [4:0]    count;
  logic [31:0]   acc;
  logic [31:0]   quo;
  logic [31:0]   mb;
  logic          op_div;
  logic          neg_lo;
  logic          neg_hi;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          busy_w;
  logic          accept;
  logic          start;
  logic          is_div_req;
  logic          signed_req;
  logic          b_zero;
  logic [32:0]   add_a;
  logic [32:0]   add_b;
  logic [32:0]   add_sum;
  logic [63:0]   prod_fix;
  logic [31:0]   quo_fix;
  logic [31:0]   rem_fix;

  assign is_div_req = (bus.muldiv_op == OP_DIV);
  assign signed_req = ~bus.muldiv_op_u;
  assign b_zero     = (bus.B == 32'd0);
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A request coinciding with flush is dropped, and flush wins over any state.
  always_comb begin
    busy_w    = (state != IDLE);
    accept    = bus.req_valid & ~busy_w & ~bus.flush;
    start     = accept & ((bus.muldiv_op == OP_MUL) | (bus.muldiv_op == OP_DIV));
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ITER;
      ITER:    if (count == 5'd0) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
    bus.busy  = busy_w;
    bus.stall = bus.req_valid & busy_w;
  end

  // DIV feeds the adder {rem,next dividend bit} - divisor; MUL adds the
  // multiplicand to the upper half when the current multiplier bit is set.
  always_comb begin
    add_a    = op_div ? {acc, quo[31]} : {1'b0, acc};
    add_b    = op_div ? ~{1'b0, mb} : (quo[0] ? {1'b0, mb} : 33'd0);
    add_sum  = add_a + add_b + {32'd0, op_div};
    prod_fix = neg_lo ? (64'd0 - {acc, quo}) : {acc, quo};
    quo_fix  = neg_lo ? (32'd0 - quo) : quo;
    rem_fix  = neg_hi ? (32'd0 - acc) : acc;
  end

  // Divide-by-zero naturally yields an all-ones quotient and |A| remainder;
  // suppressing quotient negation and giving the remainder A's sign returns A.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 5'd0;
      acc    <= 32'd0;
      quo    <= 32'd0;
      mb     <= 32'd0;
      op_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (bus.muldiv_op)
              OP_MTHI: hi_q <= bus.A;
              OP_MTLO: lo_q <= bus.A;
              OP_MUL, OP_DIV: begin
                op_div <= is_div_req;
                count  <= ITER_LAST;
                acc    <= 32'd0;
                quo    <= signed_req ? abs32(bus.A) : bus.A;
                mb     <= signed_req ? abs32(bus.B) : bus.B;
                neg_lo <= signed_req & (bus.A[31] ^ bus.B[31]) & ~(is_div_req & b_zero);
                neg_hi <= signed_req & bus.A[31] & is_div_req;
              end
              default: ;
            endcase
          end
        end
        ITER: begin
          if (count != 5'd0) count <= count - 5'd1;
          if (op_div) begin
            if (!add_sum[32]) begin
              acc <= add_sum[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              acc <= add_a[31:0];
              quo <= {quo[30:0], 1'b0};
            end
          end else begin
            acc <= add_sum[32:1];
            quo <= {add_sum[0], quo[31:1]};
          end
        end
        FIXUP: begin
          if (!bus.flush) begin
            if (op_div) begin
              lo_q <= quo_fix;
              hi_q <= rem_fix;
            end else begin
              hi_q <= prod_fix[63:32];
              lo_q <= prod_fix[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
